// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, compare selects, FSM states and legality check
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NAND = 4'b1101;
    localparam logic [3:0] ALU_COMP = 4'b0111;

    localparam logic [2:0] CMP_SLT  = 3'd0;
    localparam logic [2:0] CMP_SGT  = 3'd1;
    localparam logic [2:0] CMP_SLE  = 3'd2;
    localparam logic [2:0] CMP_SGE  = 3'd3;
    localparam logic [2:0] CMP_SNE  = 3'd4;
    localparam logic [2:0] CMP_SLTU = 3'd5;
    localparam logic [2:0] CMP_SEQ  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [3:0] ctrl, input logic [2:0] comp);
        case (ctrl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR, ALU_NAND: return 1'b1;
            ALU_COMP: return (comp != 3'b111);
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit combinational ALU with zero, carry and signed overflow flags
module alu
    import alu_pkg::*;
(
    input  logic        rst_n,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [3:0]  ALU_control,
    input  logic [2:0]  comp,
    output logic [31:0] result,
    output logic        zero,
    output logic        cout,
    output logic        overflow
);

    logic [32:0] w_add;
    logic [32:0] w_sub;
    logic        w_lt;
    logic        w_ltu;
    logic        w_eq;
    logic        w_cond;
    logic [31:0] w_res;
    logic        w_cout;
    logic        w_ovf;

    assign w_add = {1'b0, src1} + {1'b0, src2};
    assign w_sub = {1'b0, src1} + {1'b0, ~src2} + 33'd1;
    assign w_lt  = $signed(src1) < $signed(src2);
    assign w_ltu = src1 < src2;
    assign w_eq  = src1 == src2;

    always_comb begin
        w_cond = 1'b0;
        case (comp)
            CMP_SLT:  w_cond = w_lt;
            CMP_SGT:  w_cond = !w_lt && !w_eq;
            CMP_SLE:  w_cond = w_lt || w_eq;
            CMP_SGE:  w_cond = !w_lt;
            CMP_SNE:  w_cond = !w_eq;
            CMP_SLTU: w_cond = w_ltu;
            CMP_SEQ:  w_cond = w_eq;
            default:  w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_res  = '0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        case (ALU_control)
            ALU_AND:  w_res = src1 & src2;
            ALU_OR:   w_res = src1 | src2;
            ALU_NOR:  w_res = ~(src1 | src2);
            ALU_NAND: w_res = ~(src1 & src2);
            ALU_ADD: begin
                w_res  = w_add[31:0];
                w_cout = w_add[32];
                w_ovf  = (src1[31] == src2[31]) && (w_add[31] != src1[31]);
            end
            // cout on SUB is the carry of a + ~b + 1, i.e. 1 when no borrow
            ALU_SUB: begin
                w_res  = w_sub[31:0];
                w_cout = w_sub[32];
                w_ovf  = (src1[31] != src2[31]) && (w_sub[31] != src1[31]);
            end
            ALU_COMP: w_res = {31'd0, w_cond};
            default:  w_res = '0;
        endcase
    end

    assign result   = rst_n ? w_res : 32'd0;
    assign zero     = rst_n && (w_res == 32'd0);
    assign cout     = rst_n && w_cout;
    assign overflow = rst_n && w_ovf;

endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant, prio selects the winner on contention
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = prio ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU between two requesters, one op in flight
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int   DATA_W  = 32,
    parameter logic RR_INIT = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_src1,
    input  logic [2*DATA_W-1:0] req_src2,
    input  logic [7:0]          req_ctrl,
    input  logic [5:0]          req_comp,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [DATA_W-1:0]   rsp_result,
    output logic                rsp_zero,
    output logic                rsp_cout,
    output logic                rsp_overflow,
    output logic                rsp_err
);

    state_t              r_state;
    logic                r_prio;
    logic                r_id;
    logic                r_illegal;
    logic [DATA_W-1:0]   r_src1;
    logic [DATA_W-1:0]   r_src2;
    logic [3:0]          r_ctrl;
    logic [2:0]          r_comp;

    logic [1:0]          w_gnt;
    logic                w_gnt_id;
    logic [3:0]          w_sel_ctrl;
    logic [2:0]          w_sel_comp;
    logic [3:0]          w_alu_ctrl;
    logic [DATA_W-1:0]   w_result;
    logic                w_zero;
    logic                w_cout;
    logic                w_overflow;

    rr_arb2 u_arb (
        .req  (req_valid),
        .prio (r_prio),
        .gnt  (w_gnt)
    );

    // Ready is combinational from valid so a requester withdrawing in the grant cycle is never accepted
    assign req_ready  = (rst_n && r_state == ST_IDLE) ? w_gnt : 2'b00;
    assign w_gnt_id   = w_gnt[1];
    assign w_sel_ctrl = w_gnt_id ? req_ctrl[7:4] : req_ctrl[3:0];
    assign w_sel_comp = w_gnt_id ? req_comp[5:3] : req_comp[2:0];
    assign w_alu_ctrl = r_illegal ? ALU_AND : r_ctrl;

    alu u_alu (
        .rst_n       (rst_n),
        .src1        (r_src1),
        .src2        (r_src2),
        .ALU_control (w_alu_ctrl),
        .comp        (r_comp),
        .result      (w_result),
        .zero        (w_zero),
        .cout        (w_cout),
        .overflow    (w_overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_prio       <= RR_INIT;
            r_id         <= 1'b0;
            r_illegal    <= 1'b0;
            r_src1       <= '0;
            r_src2       <= '0;
            r_ctrl       <= '0;
            r_comp       <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_cout     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_id      <= w_gnt_id;
                        r_src1    <= w_gnt_id ? req_src1[2*DATA_W-1:DATA_W] : req_src1[DATA_W-1:0];
                        r_src2    <= w_gnt_id ? req_src2[2*DATA_W-1:DATA_W] : req_src2[DATA_W-1:0];
                        r_ctrl    <= w_sel_ctrl;
                        r_comp    <= w_sel_comp;
                        r_illegal <= !op_legal(w_sel_ctrl, w_sel_comp);
                        r_prio    <= ~w_gnt_id;
                        r_state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_valid    <= 1'b1;
                    rsp_id       <= r_id;
                    rsp_err      <= r_illegal;
                    rsp_result   <= r_illegal ? '0 : w_result;
                    rsp_zero     <= !r_illegal && w_zero;
                    rsp_cout     <= !r_illegal && w_cout;
                    rsp_overflow <= !r_illegal && w_overflow;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
